// File: rtl/h14tx_pkg.sv
// Shared types and constants for the HDMI 1.4 transmit period path.
package h14tx_pkg;

  typedef logic [7:0] video_t;
  typedef video_t [2:0] pixel_t;

  typedef enum logic [1:0] {
    CONTROL  = 2'd0,
    PREAMBLE = 2'd1,
    GUARD    = 2'd2,
    VIDEO    = 2'd3
  } period_t;

  // CTL[3:0] patterns that announce the period following the preamble.
  localparam logic [3:0] H14TX_PREAMBLE_VIDEO = 4'b0001;
  localparam logic [3:0] H14TX_PREAMBLE_DATA  = 4'b0101;

endpackage

// File: rtl/h14tx_delay_line.sv
// Fixed-depth register shift line with asynchronous clear.
module h14tx_delay_line #(
  parameter int DATA_W = 1,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] line_p [STAGES];

  // Shift every stage by one each clock; reset discards all content.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) line_p[i] <= '0;
    end else begin
      line_p[0] <= din;
      for (int i = 1; i < STAGES; i++) line_p[i] <= line_p[i-1];
    end
  end

  assign dout = line_p[STAGES-1];

endmodule

// File: rtl/h14tx_period_scheduler.sv
// Video period scheduler: delays pixel/sync/DE so each qualified active line
// is preceded by a video preamble and leading guard band, and tags each
// output cycle with its period, CTL pattern and encoder active_n.
// Optional build macro H14TX_PERIOD_SCHED_STATUS_EN adds a saturating
// short-blank event counter with a synchronous clear.
module h14tx_period_scheduler
  import h14tx_pkg::*;
#(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [23:0] pixel,
  output logic [1:0]  period,
  output logic [3:0]  ctl,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [23:0] pixel_o,
  output logic        active_n,
`ifdef H14TX_PERIOD_SCHED_STATUS_EN
  input  logic        status_clr,
  output logic [15:0] short_blank_cnt,
`endif
  output logic        short_blank
);

  localparam int LOOKAHEAD = PREAMBLE_LEN + GUARD_LEN;
  localparam int CNT_W     = $clog2(LOOKAHEAD + 1);
  localparam int DLY_W     = 4 + 24;

  localparam logic [CNT_W-1:0] LOOK_C = CNT_W'(LOOKAHEAD);
  localparam logic [CNT_W-1:0] PRE_C  = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] GRD_C  = CNT_W'(GUARD_LEN - 1);

  // Input stage: low-run length and previous DE for rise qualification.
  logic [CNT_W-1:0] low_run_p0;
  logic             de_p0;
  logic             qual;

  // A rise is qualified only when enough blanking precedes it to fit the
  // whole preamble plus guard band ahead of the delayed first pixel.
  assign qual = de & ~de_p0 & (low_run_p0 >= LOOK_C);

  // Track consecutive low DE cycles, saturating at the lookahead depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_run_p0 <= '0;
      de_p0      <= 1'b0;
    end else begin
      de_p0 <= de;
      if (de)
        low_run_p0 <= '0;
      else if (low_run_p0 != LOOK_C)
        low_run_p0 <= low_run_p0 + 1'b1;
    end
  end

  // Delay stage: qual tag travels with its sample down to the output tap.
  logic [DLY_W-1:0] tap_p1;
  logic             tap_qual;
  logic             tap_de;
  logic             tap_hs;
  logic             tap_vs;
  logic [23:0]      tap_px;

  h14tx_delay_line #(
    .DATA_W (DLY_W),
    .STAGES (LOOKAHEAD)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({qual, de, hsync, vsync, pixel}),
    .dout (tap_p1)
  );

  assign {tap_qual, tap_de, tap_hs, tap_vs, tap_px} = tap_p1;

  // Period FSM: qualified rises are seen at the delay-line input, exactly
  // LOOKAHEAD stages ahead of the tap; VIDEO follows the delayed DE.
  period_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sb_d;

  // State and period-length counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CONTROL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and short-blank detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sb_d    = 1'b0;
    unique case (state_q)
      CONTROL: begin
        if (tap_de) begin
          // A line reaching the tap with no preamble started was unqualified.
          state_d = VIDEO;
          sb_d    = ~tap_qual;
        end else if (qual) begin
          state_d = PREAMBLE;
          cnt_d   = PRE_C;
        end
      end
      PREAMBLE: begin
        if (cnt_q == '0) begin
          state_d = GUARD;
          cnt_d   = GRD_C;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GUARD: begin
        if (cnt_q == '0)
          state_d = VIDEO;
        else
          cnt_d = cnt_q - 1'b1;
      end
      VIDEO: begin
        // A blank of exactly LOOKAHEAD cycles needs the next preamble to
        // start right where this line ends, with no CONTROL in between.
        if (!tap_de) begin
          if (qual) begin
            state_d = PREAMBLE;
            cnt_d   = PRE_C;
          end else begin
            state_d = CONTROL;
          end
        end
      end
      default: state_d = CONTROL;
    endcase
  end

  // Output stage: delayed sync/pixel plus period-derived tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_o     <= 1'b0;
      vsync_o     <= 1'b0;
      pixel_o     <= '0;
      ctl         <= '0;
      active_n    <= 1'b1;
      short_blank <= 1'b0;
    end else begin
      hsync_o     <= tap_hs;
      vsync_o     <= tap_vs;
      pixel_o     <= tap_px;
      ctl         <= (state_d == PREAMBLE) ? H14TX_PREAMBLE_VIDEO : 4'b0000;
      active_n    <= (state_d != VIDEO);
      short_blank <= sb_d;
    end
  end

  assign period = state_q;

`ifdef H14TX_PERIOD_SCHED_STATUS_EN
  // Saturating short-blank event counter; clear wins over a coincident pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      short_blank_cnt <= '0;
    else if (status_clr)
      short_blank_cnt <= '0;
    else if (sb_d && (short_blank_cnt != 16'hFFFF))
      short_blank_cnt <= short_blank_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_h14tx_period_scheduler.sv
// Self-checking bench for h14tx_period_scheduler. The reference model keeps
// the input sample history since the last reset and derives every output
// from the line rules: output = sample 10 back, a qualified rise opens 8
// preamble then 2 guard cycles, an unqualified rise pulses short_blank.
`timescale 1ns/1ps
module tb_h14tx_period_scheduler;
  import h14tx_pkg::*;

  localparam int PRE = 8;
  localparam int GRD = 2;
  localparam int LA  = PRE + GRD;

  logic        clk = 1'b0;
  logic        rst;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [23:0] pixel;
  logic [1:0]  period;
  logic [3:0]  ctl;
  logic        hsync_o;
  logic        vsync_o;
  logic [23:0] pixel_o;
  logic        active_n;
  logic        short_blank;
`ifdef H14TX_PERIOD_SCHED_STATUS_EN
  logic        status_clr;
  logic [15:0] short_blank_cnt;
  int          exp_cnt = 0;
`endif

  always #5 clk = ~clk;

  h14tx_period_scheduler #(
    .PREAMBLE_LEN (PRE),
    .GUARD_LEN    (GRD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .de              (de),
    .hsync           (hsync),
    .vsync           (vsync),
    .pixel           (pixel),
    .period          (period),
    .ctl             (ctl),
    .hsync_o         (hsync_o),
    .vsync_o         (vsync_o),
    .pixel_o         (pixel_o),
    .active_n        (active_n),
`ifdef H14TX_PERIOD_SCHED_STATUS_EN
    .status_clr      (status_clr),
    .short_blank_cnt (short_blank_cnt),
`endif
    .short_blank     (short_blank)
  );

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] px;
  } samp_t;

  samp_t hist[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  function automatic bit is_rise(int r);
    return hist[r].de && (r == 0 || !hist[r-1].de);
  endfunction

  function automatic bit is_qual(int r);
    if (!is_rise(r) || r < LA) return 1'b0;
    for (int k = r - LA; k < r; k++)
      if (hist[k].de) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at sample %0d: observed %0h expected %0h", tag, hist.size(), obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_period"}, 32'(period), 32'(CONTROL));
    chk({tag, "_ctl"}, 32'(ctl), 32'd0);
    chk({tag, "_hsync_o"}, 32'(hsync_o), 32'd0);
    chk({tag, "_vsync_o"}, 32'(vsync_o), 32'd0);
    chk({tag, "_pixel_o"}, 32'(pixel_o), 32'd0);
    chk({tag, "_active_n"}, 32'(active_n), 32'd1);
    chk({tag, "_short_blank"}, 32'(short_blank), 32'd0);
`ifdef H14TX_PERIOD_SCHED_STATUS_EN
    exp_cnt = 0;
    chk({tag, "_sb_cnt"}, 32'(short_blank_cnt), 32'd0);
`endif
  endtask

  task automatic check_outputs();
    int         n   = hist.size() - 1;
    samp_t      s   = '0;
    logic [1:0] ep  = CONTROL;
    bit         esb = 1'b0;
    if (n >= LA) begin
      s   = hist[n-LA];
      esb = is_rise(n-LA) && !is_qual(n-LA);
    end
    if (s.de) begin
      ep = VIDEO;
    end else begin
      for (int r = n - LA + 1; r <= n; r++)
        if (r >= 0 && is_qual(r)) ep = (n - r < PRE) ? PREAMBLE : GUARD;
    end
    chk("period", 32'(period), 32'(ep));
    chk("ctl", 32'(ctl), (ep == PREAMBLE) ? 32'h1 : 32'h0);
    chk("active_n", 32'(active_n), (ep == VIDEO) ? 32'd0 : 32'd1);
    chk("short_blank", 32'(short_blank), 32'(esb));
    chk("hsync_o", 32'(hsync_o), 32'(s.hs));
    chk("vsync_o", 32'(vsync_o), 32'(s.vs));
    chk("pixel_o", 32'(pixel_o), 32'(s.px));
`ifdef H14TX_PERIOD_SCHED_STATUS_EN
    if (status_clr) exp_cnt = 0;
    else if (esb && exp_cnt < 65535) exp_cnt++;
    chk("sb_cnt", 32'(short_blank_cnt), 32'(exp_cnt));
`endif
  endtask

  // Drive one input sample, clock it in, and compare outputs just after.
  task automatic step(input logic d);
    samp_t s;
    de    = d;
    hsync = 1'($urandom);
    vsync = 1'($urandom);
    pixel = 24'($urandom);
    s.de = d;
    s.hs = hsync;
    s.vs = vsync;
    s.px = pixel;
    hist.push_back(s);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run_line(input int blank, input int active);
    repeat (blank) step(1'b0);
    repeat (active) step(1'b1);
  endtask

  // Assert reset for about one clock; outputs must clear without an edge.
  task automatic apply_reset(input logic de_during);
    rst = 1'b1;
    de  = de_during;
    #1;
    chk_reset("async_rst");
    @(posedge clk);
    #1;
    chk_reset("held_rst");
    rst = 1'b0;
    hist.delete();
  endtask

  initial begin
    rst   = 1'b1;
    de    = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    pixel = '0;
`ifdef H14TX_PERIOD_SCHED_STATUS_EN
    status_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst = 1'b0;
    hist.delete();

    // Basic scheduled line, then exact-minimum and one-short blanks.
    run_line(20, 16);
    run_line(10, 16);
    run_line(9, 16);
    repeat (12) step(1'b0);

    // DE held high across reset release: first line unqualified.
    run_line(12, 4);
    apply_reset(1'b1);
    repeat (12) step(1'b1);
    run_line(30, 16);

    // Reset in the middle of a preamble aborts that line.
    run_line(15, 3);
    apply_reset(1'b0);
    run_line(20, 8);

    // Randomised line/blank lengths around the qualification boundary.
    for (int i = 0; i < 40; i++)
      run_line($urandom_range(3, 25), $urandom_range(1, 30));
    repeat (15) step(1'b0);

`ifdef H14TX_PERIOD_SCHED_STATUS_EN
    apply_reset(1'b0);
    run_line(20, 4);
    for (int i = 0; i < 3; i++) run_line(5, 6);
    repeat (12) step(1'b0);
    chk("sb_cnt_three", 32'(short_blank_cnt), 32'd3);
    status_clr = 1'b1;
    run_line(5, 6);
    repeat (12) step(1'b0);
    status_clr = 1'b0;
    chk("sb_cnt_cleared", 32'(short_blank_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
